// File: rtl/mcpu_core_pkg.sv
// rtl/mcpu_core_pkg.sv - shared widths, fetch queue entry and fetch state for the core front-end
package mcpu_core_pkg;

    localparam int PKT_W   = 128;
    localparam int PADDR_W = 28;

    typedef struct packed {
        logic               pf;
        logic [PADDR_W-1:0] pc;
        logic [PKT_W-1:0]   packet;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/mcpu_fifo_sync.sv
// rtl/mcpu_fifo_sync.sv - synchronous FIFO with flush, occupancy count and register-array head
module mcpu_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign head_valid = (count_q != '0);
    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_ok     = pop & head_valid;
    // a push into a full queue is only legal when the head leaves in the same cycle
    assign push_ok    = push & (~full | pop_ok);
    assign head_data  = mem[rd_ptr];
    assign count      = count_q;

    // pointers and occupancy; flush empties the queue and overrides any push or pop
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
        end
    end

    // entry storage holds data only, so it carries no reset
    always_ff @(posedge clkrst_core_clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // upstream credit accounting must never overflow the queue
    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst && !flush) begin
            assert (!(push && full && !pop_ok));
        end
    end

endmodule

// File: rtl/mcpu_core_ifetch.sv
// rtl/mcpu_core_ifetch.sv - sequential packet fetch, credit-limited issue, redirect and fault halt
module mcpu_core_ifetch
    import mcpu_core_pkg::*;
#(
    parameter logic [PADDR_W-1:0] RESET_PC = 28'h0000000,
    parameter int                 DEPTH    = 4,
    parameter int                 PTR_W    = 2
) (
    input  logic               clkrst_core_clk,
    input  logic               clkrst_core_rst,
    output logic [PADDR_W-1:0] il1c_addr,
    output logic               il1c_re,
    input  logic [PKT_W-1:0]   il1c_packet,
    input  logic               il1c_ready,
    input  logic               il1c_pf,
    output logic               f2d_valid,
    output logic [PKT_W-1:0]   f2d_packet,
    output logic [PADDR_W-1:0] f2d_pc,
    output logic               f2d_pf,
    input  logic               d2f_ready,
    input  logic               f_redirect,
    input  logic [PADDR_W-1:0] f_redirect_pc
);

    fetch_state_t       state_q, state_n;
    logic [PADDR_W-1:0] pc_req_q, pc_req_n;
    logic [PADDR_W-1:0] inflight_addr_q, inflight_addr_n;
    logic [PADDR_W-1:0] pend_pc_q, pend_pc_n;
    logic               inflight_q, inflight_n;
    logic               stale_q, stale_n;
    logic               pend_q, pend_n;
    logic               re_q, re_n;
    logic               accept;
    logic               resp;
    logic               push;
    logic               pop;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_n;
    logic [PTR_W+1:0]   credit;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;

    assign accept     = re_q & il1c_ready;
    assign resp       = il1c_ready & inflight_q;
    assign push       = resp & ~stale_q & ~f_redirect;
    assign pop        = f2d_valid & d2f_ready;
    assign push_entry = {il1c_pf, inflight_addr_q, il1c_packet};

    assign il1c_addr  = pc_req_q;
    assign il1c_re    = re_q;
    assign f2d_packet = head_entry.packet;
    assign f2d_pc     = head_entry.pc;
    assign f2d_pf     = f2d_valid & head_entry.pf;

    mcpu_fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .flush           (f_redirect),
        .push            (push),
        .push_data       (push_entry),
        .pop             (pop),
        .head_data       (head_entry),
        .head_valid      (f2d_valid),
        .count           (count)
    );

    // next-state: the cache interface only advances on il1c_ready, so addr/re hold while stalled
    always_comb begin
        state_n         = state_q;
        pc_req_n        = pc_req_q;
        inflight_addr_n = inflight_addr_q;
        pend_pc_n       = pend_pc_q;
        inflight_n      = inflight_q;
        stale_n         = stale_q;
        pend_n          = pend_q;
        re_n            = re_q;
        credit          = '0;
        count_n         = f_redirect ? '0
                        : count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

        if (f_redirect) begin
            pend_pc_n = f_redirect_pc;
        end

        if (il1c_ready) begin
            inflight_n = accept;
            if (accept) begin
                pc_req_n        = pc_req_q + PADDR_W'(1);
                inflight_addr_n = pc_req_q;
            end
            if (push && il1c_pf) begin
                state_n = FETCH_HALT;
            end
            // a request accepted while a redirect takes effect belongs to the old stream
            stale_n = accept & (f_redirect | pend_q);
            if (f_redirect) begin
                pc_req_n = f_redirect_pc;
                state_n  = FETCH_RUN;
                pend_n   = 1'b0;
            end else if (pend_q) begin
                pc_req_n = pend_pc_q;
                state_n  = FETCH_RUN;
                pend_n   = 1'b0;
            end
            // issue only if every outstanding request is guaranteed a queue slot
            credit = {1'b0, count_n} + {{(PTR_W+1){1'b0}}, inflight_n};
            re_n   = (state_n == FETCH_RUN) & ~pend_n & (credit < (PTR_W+2)'(DEPTH));
        end else if (f_redirect) begin
            pend_n  = 1'b1;
            stale_n = stale_q | inflight_q | re_q;
        end
    end

    // state register
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q         <= FETCH_RUN;
            pc_req_q        <= RESET_PC;
            inflight_addr_q <= RESET_PC;
            pend_pc_q       <= '0;
            inflight_q      <= 1'b0;
            stale_q         <= 1'b0;
            pend_q          <= 1'b0;
            re_q            <= 1'b0;
        end else begin
            state_q         <= state_n;
            pc_req_q        <= pc_req_n;
            inflight_addr_q <= inflight_addr_n;
            pend_pc_q       <= pend_pc_n;
            inflight_q      <= inflight_n;
            stale_q         <= stale_n;
            pend_q          <= pend_n;
            re_q            <= re_n;
        end
    end

endmodule
